// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and default geometry for the IFU instruction cache
// Purpose: FSM state enum, tag-array entry struct and default-parameter localparams
//          used by ifu_icache_sa and ifu_plru_tree.
// Ports:   none (package).
package ifu_pkg;

    localparam int ICACHE_NUM_WAYS     = 4;
    localparam int ICACHE_NUM_SETS     = 8;
    localparam int ICACHE_ADDR_WIDTH   = 32;
    localparam int ICACHE_OFFSET_WIDTH = 4;
    localparam int ICACHE_LINE_WIDTH   = 128;

    // Tag field is sized for the widest supported address, so one struct type
    // serves any cache geometry; tags are stored zero-extended.
    localparam int ICACHE_TAG_MAX_W    = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        RESP      = 2'd3
    } icache_state_t;

    typedef struct packed {
        logic                        valid;
        logic [ICACHE_TAG_MAX_W-1:0] tag;
    } icache_tag_t;

endpackage

// File: rtl/ifu_plru_tree.sv
// rtl/ifu_plru_tree.sv - combinational tree-PLRU update and victim selection for one set
// Purpose: given a set's heap-ordered PLRU bits (node 0 = root, children 2i+1/2i+2,
//          bit 0 = victim on the left), return the tree after an access to accessWay
//          and the way the current tree points at.
// Ports:   treeIn    - current tree bits
//          accessWay - way being hit or filled
//          treeOut   - tree with the access path pointing away from accessWay
//          victimWay - PLRU victim of treeIn
module ifu_plru_tree #(
    parameter int NUM_WAYS = 4,
    parameter int WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] treeIn,
    input  logic [WAY_BITS-1:0] accessWay,
    output logic [NUM_WAYS-2:0] treeOut,
    output logic [WAY_BITS-1:0] victimWay
);

    localparam int TREE_W = NUM_WAYS - 1;

    always_comb begin
        int                nodeUpd;
        int                nodeVic;
        logic              dir;
        logic              vicBit;
        logic [TREE_W-1:0] mask;

        treeOut   = treeIn;
        victimWay = '0;
        nodeUpd   = 0;
        nodeVic   = 0;
        dir       = 1'b0;
        vicBit    = 1'b0;
        mask      = '0;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            // Update walk: way bits MSB first select the path; each node on it
            // is set to point at the other subtree.
            dir     = |(accessWay & (WAY_BITS'(1) << (WAY_BITS - 1 - lvl)));
            mask    = TREE_W'(1) << nodeUpd;
            treeOut = dir ? (treeOut & ~mask) : (treeOut | mask);
            nodeUpd = 2 * nodeUpd + 1 + int'(dir);

            // Victim walk follows the unmodified tree.
            mask      = TREE_W'(1) << nodeVic;
            vicBit    = |(treeIn & mask);
            victimWay = (victimWay << 1) | WAY_BITS'(vicBit);
            nodeVic   = 2 * nodeVic + 1 + int'(vicBit);
        end
    end

endmodule

// File: rtl/ifu_icache_sa.sv
// rtl/ifu_icache_sa.sv - N-way set-associative IFU instruction cache with tree-PLRU and flush
// Purpose: blocking single-miss instruction cache between CPU fetch and memory.
//          Hits respond one cycle after acceptance; misses request the line,
//          wait for the matching fill, install it and respond.
// Ports:   Clock, Rst (sync, active-high)
//          cpu_req*  - fetch request (valid/ready), flushIn invalidates all lines
//          cpu_rsp*  - one-cycle response pulse with address and line
//          mem_req*  - line fill request (valid/ready), line address tag
//          mem_rsp*  - fill data with its line address
// Config:  IFU_ICACHE_PERF_CNT_EN adds perf_hitCntOut / perf_missCntOut.
module ifu_icache_sa
    import ifu_pkg::*;
#(
    parameter int NUM_WAYS     = ICACHE_NUM_WAYS,
    parameter int NUM_SETS     = ICACHE_NUM_SETS,
    parameter int ADDR_WIDTH   = ICACHE_ADDR_WIDTH,
    parameter int OFFSET_WIDTH = ICACHE_OFFSET_WIDTH,
    parameter int LINE_WIDTH   = ICACHE_LINE_WIDTH,
    parameter int SET_BITS     = $clog2(NUM_SETS),
    parameter int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH - SET_BITS,
    parameter int LADDR_W      = ADDR_WIDTH - OFFSET_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  cpu_reqValidIn,
    input  logic [ADDR_WIDTH-1:0] cpu_reqAddrIn,
    output logic                  cpu_reqReadyOut,
    input  logic                  flushIn,
    output logic                  cpu_rspValidOut,
    output logic [ADDR_WIDTH-1:0] cpu_rspAddrOut,
    output logic [LINE_WIDTH-1:0] cpu_rspInsLineOut,
    output logic                  mem_reqValidOut,
    input  logic                  mem_reqReadyIn,
    output logic [LADDR_W-1:0]    mem_reqTagOut,
    input  logic                  mem_rspValidIn,
    input  logic [LADDR_W-1:0]    mem_rspTagIn,
    input  logic [LINE_WIDTH-1:0] mem_rspInsLineIn
`ifdef IFU_ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           perf_hitCntOut,
    output logic [31:0]           perf_missCntOut
`endif
);

    localparam int WAY_BITS = $clog2(NUM_WAYS);
    localparam int SET_IW   = (SET_BITS == 0) ? 1 : SET_BITS;

    icache_state_t state, stateNext;

    icache_tag_t           tagArr  [NUM_SETS][NUM_WAYS];
    logic [LINE_WIDTH-1:0] dataArr [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-2:0]   plruArr [NUM_SETS];

    logic [ADDR_WIDTH-1:0] reqAddrQ;
    logic                  rspValidQ;
    logic [LINE_WIDTH-1:0] rspLineQ;

    logic [TAG_WIDTH-1:0]        inTagRaw, pendTagRaw;
    logic [ICACHE_TAG_MAX_W-1:0] inTag, pendTag;
    logic [SET_IW-1:0]           inSet, pendSet, actSet;
    logic                        accept, flushAccept, fillMatch, hit, freeFound;
    logic [WAY_BITS-1:0]         hitWay, victimWay, plruVictim, accessWay;
    logic [NUM_WAYS-2:0]         treeNew;

    // Lookup uses the incoming address; the pending miss uses the registered one.
    assign inTagRaw   = cpu_reqAddrIn[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign pendTagRaw = reqAddrQ[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign inTag      = ICACHE_TAG_MAX_W'(inTagRaw);
    assign pendTag    = ICACHE_TAG_MAX_W'(pendTagRaw);
    assign inSet      = SET_IW'((cpu_reqAddrIn >> OFFSET_WIDTH) & ADDR_WIDTH'(NUM_SETS - 1));
    assign pendSet    = SET_IW'((reqAddrQ >> OFFSET_WIDTH) & ADDR_WIDTH'(NUM_SETS - 1));

    // Flush has priority over a simultaneous request.
    assign cpu_reqReadyOut = (state == IDLE) && !flushIn && !Rst;
    assign accept          = cpu_reqValidIn && cpu_reqReadyOut;
    assign flushAccept     = flushIn && (state == IDLE) && !Rst;
    assign fillMatch       = (state == MISS_WAIT) && mem_rspValidIn &&
                             (mem_rspTagIn == reqAddrQ[ADDR_WIDTH-1:OFFSET_WIDTH]);

    assign cpu_rspValidOut   = rspValidQ;
    assign cpu_rspAddrOut    = reqAddrQ;
    assign cpu_rspInsLineOut = rspLineQ;
    assign mem_reqValidOut   = (state == MISS_REQ);
    assign mem_reqTagOut     = reqAddrQ[ADDR_WIDTH-1:OFFSET_WIDTH];

    always_comb begin
        hit    = 1'b0;
        hitWay = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && tagArr[inSet][w].valid && (tagArr[inSet][w].tag == inTag)) begin
                hit    = 1'b1;
                hitWay = WAY_BITS'(w);
            end
        end
    end

    // Fill victim: lowest invalid way, falling back to the tree's choice.
    always_comb begin
        freeFound = 1'b0;
        victimWay = plruVictim;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!freeFound && !tagArr[pendSet][w].valid) begin
                freeFound = 1'b1;
                victimWay = WAY_BITS'(w);
            end
        end
    end

    // One tree evaluator shared between the lookup set (IDLE) and the miss set.
    assign actSet    = (state == IDLE) ? inSet : pendSet;
    assign accessWay = (state == IDLE) ? hitWay : victimWay;

    ifu_plru_tree #(
        .NUM_WAYS (NUM_WAYS),
        .WAY_BITS (WAY_BITS)
    ) uPlru (
        .treeIn    (plruArr[actSet]),
        .accessWay (accessWay),
        .treeOut   (treeNew),
        .victimWay (plruVictim)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      if (accept && !hit)  stateNext = MISS_REQ;
            MISS_REQ:  if (mem_reqReadyIn)  stateNext = MISS_WAIT;
            MISS_WAIT: if (fillMatch)       stateNext = RESP;
            RESP:                           stateNext = IDLE;
            default:                        stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state     <= IDLE;
            reqAddrQ  <= '0;
            rspValidQ <= 1'b0;
            rspLineQ  <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                plruArr[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) tagArr[s][w].valid <= 1'b0;
            end
        end else begin
            state     <= stateNext;
            rspValidQ <= 1'b0;
            if (accept) begin
                reqAddrQ <= cpu_reqAddrIn;
                if (hit) begin
                    rspValidQ      <= 1'b1;
                    rspLineQ       <= dataArr[inSet][hitWay];
                    plruArr[inSet] <= treeNew;
                end
            end
            if (flushAccept) begin
                for (int s = 0; s < NUM_SETS; s++)
                    for (int w = 0; w < NUM_WAYS; w++) tagArr[s][w].valid <= 1'b0;
            end
            if (fillMatch) begin
                tagArr[pendSet][victimWay] <= '{valid: 1'b1, tag: pendTag};
                rspValidQ                  <= 1'b1;
                rspLineQ                   <= mem_rspInsLineIn;
                plruArr[pendSet]           <= treeNew;
            end
        end
    end

    // Line data needs no reset; its valid bit lives in the tag array.
    always_ff @(posedge Clock) begin
        if (!Rst && fillMatch) dataArr[pendSet][victimWay] <= mem_rspInsLineIn;
    end

`ifdef IFU_ICACHE_PERF_CNT_EN
    always_ff @(posedge Clock) begin
        if (Rst || flushAccept) begin
            perf_hitCntOut  <= '0;
            perf_missCntOut <= '0;
        end else if (accept) begin
            if (hit) perf_hitCntOut  <= perf_hitCntOut + 32'd1;
            else     perf_missCntOut <= perf_missCntOut + 32'd1;
        end
    end
`else
    // Counters absent in this build; cache behaviour is unchanged.
`endif

endmodule

// File: tb/tb_ifu_icache_sa.sv
// tb/tb_ifu_icache_sa.sv - scoreboard bench for ifu_icache_sa with a behavioural cache model
module tb_ifu_icache_sa;

    logic         Clock = 1'b0;
    logic         Rst;
    logic         cpu_reqValidIn;
    logic [31:0]  cpu_reqAddrIn;
    logic         cpu_reqReadyOut;
    logic         flushIn;
    logic         cpu_rspValidOut;
    logic [31:0]  cpu_rspAddrOut;
    logic [127:0] cpu_rspInsLineOut;
    logic         mem_reqValidOut;
    logic         mem_reqReadyIn;
    logic [27:0]  mem_reqTagOut;
    logic         mem_rspValidIn;
    logic [27:0]  mem_rspTagIn;
    logic [127:0] mem_rspInsLineIn;
`ifdef IFU_ICACHE_PERF_CNT_EN
    logic [31:0]  perfHit, perfMiss;
`endif

    ifu_icache_sa dut (
        .Clock             (Clock),
        .Rst               (Rst),
        .cpu_reqValidIn    (cpu_reqValidIn),
        .cpu_reqAddrIn     (cpu_reqAddrIn),
        .cpu_reqReadyOut   (cpu_reqReadyOut),
        .flushIn           (flushIn),
        .cpu_rspValidOut   (cpu_rspValidOut),
        .cpu_rspAddrOut    (cpu_rspAddrOut),
        .cpu_rspInsLineOut (cpu_rspInsLineOut),
        .mem_reqValidOut   (mem_reqValidOut),
        .mem_reqReadyIn    (mem_reqReadyIn),
        .mem_reqTagOut     (mem_reqTagOut),
        .mem_rspValidIn    (mem_rspValidIn),
        .mem_rspTagIn      (mem_rspTagIn),
`ifdef IFU_ICACHE_PERF_CNT_EN
        .perf_hitCntOut    (perfHit),
        .perf_missCntOut   (perfMiss),
`endif
        .mem_rspInsLineIn  (mem_rspInsLineIn)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] line;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: 8 sets x 4 ways of line addresses, PLRU as node arrays.
    int          mValid [8][4];
    logic [27:0] mLa    [8][4];
    int          mTree  [8][3];
    int          mHits, mMisses;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] memLine(input logic [27:0] la);
        logic [31:0] x;
        if (la == 28'h4) return {16{8'hA5}};
        x = {4'h0, la} * 32'h9E3779B1;
        return {x, ~x, x ^ 32'h5A5A5A5A, {4'h0, la}};
    endfunction

    function automatic void mReset();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 4; w++) mValid[s][w] = 0;
            for (int n = 0; n < 3; n++) mTree[s][n] = 0;
        end
        mHits = 0;
        mMisses = 0;
    endfunction

    function automatic void mFlush();
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 4; w++) mValid[s][w] = 0;
        mHits = 0;
        mMisses = 0;
    endfunction

    function automatic int mLookup(input logic [27:0] la);
        int s = int'(la % 8);
        for (int w = 0; w < 4; w++)
            if (mValid[s][w] != 0 && mLa[s][w] == la) return w;
        return -1;
    endfunction

    // Range halving: at each node the accessed half is marked recent.
    function automatic void mTouch(input int s, input int w);
        int lo = 0, n = 4, node = 0, half;
        while (n > 1) begin
            half = n / 2;
            if (w < lo + half) begin
                mTree[s][node] = 1;
                node = 2 * node + 1;
            end else begin
                mTree[s][node] = 0;
                lo = lo + half;
                node = 2 * node + 2;
            end
            n = half;
        end
    endfunction

    function automatic int mVictim(input int s);
        int lo = 0, n = 4, node = 0;
        for (int w = 0; w < 4; w++) if (mValid[s][w] == 0) return w;
        while (n > 1) begin
            if (mTree[s][node] == 0) node = 2 * node + 1;
            else begin
                lo = lo + n / 2;
                node = 2 * node + 2;
            end
            n = n / 2;
        end
        return lo;
    endfunction

    always @(negedge Clock) begin
        if (!Rst && cpu_rspValidOut === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=%0h required=none", cpu_rspAddrOut);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                chk("rsp_addr", cpu_rspAddrOut, e.addr);
                chk("rsp_line", cpu_rspInsLineOut, e.line);
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic waitReady();
        int n = 0;
        while (cpu_reqReadyOut !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", cpu_reqReadyOut, 1);
    endtask

    task automatic doReq(input logic [31:0] a, input int hold, input bit badFill, input bit rstMid);
        logic [27:0] la = a[31:4];
        int s = int'(la % 8);
        int w;
        waitReady();
        w = mLookup(la);
        cpu_reqValidIn = 1'b1;
        cpu_reqAddrIn  = a;
        if (w >= 0) begin
            mTouch(s, w);
            expQ.push_back('{a, memLine(la)});
            mHits++;
        end else begin
            mMisses++;
        end
        tick();
        cpu_reqValidIn = 1'b0;
        if (w >= 0) begin
            chk("hit_no_memreq", mem_reqValidOut, 0);
            return;
        end
        chk("miss_memreq", mem_reqValidOut, 1);
        chk("miss_tag", mem_reqTagOut, la);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", mem_reqValidOut, 1);
            chk("hold_tag", mem_reqTagOut, la);
            chk("hold_ready", cpu_reqReadyOut, 0);
        end
        mem_reqReadyIn = 1'b1;
        tick();
        mem_reqReadyIn = 1'b0;
        chk("memreq_drop", mem_reqValidOut, 0);
        if (badFill) begin
            mem_rspValidIn   = 1'b1;
            mem_rspTagIn     = la + 28'h1;
            mem_rspInsLineIn = {4{$urandom}};
            tick();
            mem_rspValidIn = 1'b0;
            chk("badfill_no_rsp", cpu_rspValidOut, 0);
            tick();
        end
        if (rstMid) begin
            Rst = 1'b1;
            tick();
            Rst = 1'b0;
            mReset();
            mem_rspValidIn   = 1'b1;
            mem_rspTagIn     = la;
            mem_rspInsLineIn = memLine(la);
            tick();
            mem_rspValidIn = 1'b0;
            chk("rst_fill_no_rsp", cpu_rspValidOut, 0);
            chk("rst_ready", cpu_reqReadyOut, 1);
            return;
        end
        w = mVictim(s);
        mValid[s][w] = 1;
        mLa[s][w]    = la;
        mTouch(s, w);
        expQ.push_back('{a, memLine(la)});
        mem_rspValidIn   = 1'b1;
        mem_rspTagIn     = la;
        mem_rspInsLineIn = memLine(la);
        tick();
        mem_rspValidIn = 1'b0;
        tick();
    endtask

    task automatic doFlush(input bit withReq, input logic [31:0] a);
        waitReady();
        flushIn = 1'b1;
        if (withReq) begin
            cpu_reqValidIn = 1'b1;
            cpu_reqAddrIn  = a;
        end
        #1;
        chk("flush_blocks_ready", cpu_reqReadyOut, 0);
        @(posedge Clock);
        #1;
        flushIn        = 1'b0;
        cpu_reqValidIn = 1'b0;
        mFlush();
        chk("flush_no_memreq", mem_reqValidOut, 0);
    endtask

    initial begin
        Rst = 1'b1;
        cpu_reqValidIn = 1'b0;
        cpu_reqAddrIn = '0;
        flushIn = 1'b0;
        mem_reqReadyIn = 1'b0;
        mem_rspValidIn = 1'b0;
        mem_rspTagIn = '0;
        mem_rspInsLineIn = '0;
        mReset();
        repeat (3) tick();
        chk("rst_ready", cpu_reqReadyOut, 0);
        chk("rst_memreq", mem_reqValidOut, 0);
        chk("rst_rspvalid", cpu_rspValidOut, 0);
        chk("rst_memtag", mem_reqTagOut, 0);
        chk("rst_rspaddr", cpu_rspAddrOut, 0);
        Rst = 1'b0;
        #1;
        chk("ready_after_rst", cpu_reqReadyOut, 1);
        tick();

        // Cold miss with 3-cycle memory backpressure, then hit.
        doReq(32'h40, 3, 1'b0, 1'b0);
        doReq(32'h40, 0, 1'b0, 1'b0);
        doReq(32'h44, 0, 1'b0, 1'b0);

        // Set 0: fill four ways, hit way 0, miss 0x200 evicts 0x100.
        doReq(32'h000, 0, 1'b0, 1'b0);
        doReq(32'h080, 1, 1'b0, 1'b0);
        doReq(32'h100, 0, 1'b0, 1'b0);
        doReq(32'h180, 2, 1'b0, 1'b0);
        doReq(32'h000, 0, 1'b0, 1'b0);
        doReq(32'h200, 0, 1'b0, 1'b0);
        doReq(32'h100, 0, 1'b0, 1'b0);
        doReq(32'h000, 0, 1'b0, 1'b0);
        doReq(32'h180, 0, 1'b0, 1'b0);

        // Flush racing a request; then a miss with a stray fill first.
        doFlush(1'b1, 32'h40);
        doReq(32'h40, 0, 1'b1, 1'b0);

        // Reset while waiting for the fill; the late fill must be dropped.
        doFlush(1'b0, 32'h0);
        doReq(32'h40, 0, 1'b0, 1'b1);
        doReq(32'h40, 0, 1'b0, 1'b0);
        doReq(32'h40, 0, 1'b0, 1'b0);
        doReq(32'h48, 0, 1'b0, 1'b0);

        // Randomised traffic: 6 tags per set forces evictions.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                doFlush($urandom_range(0, 1) == 1, {$urandom_range(0, 47), 4'h0});
            end else begin
                logic [27:0] la;
                la = 28'($urandom_range(0, 47));
                doReq({la, 4'($urandom_range(0, 15))}, $urandom_range(0, 2),
                      $urandom_range(0, 7) == 0, 1'b0);
            end
        end

        repeat (3) tick();
`ifdef IFU_ICACHE_PERF_CNT_EN
        chk("perf_hit", perfHit, mHits);
        chk("perf_miss", perfMiss, mMisses);
`endif
        chk("scoreboard_drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
